// File: rtl/vdp_cpu_port_if.sv
// VRAM request/acknowledge channel between the CPU port and the video block.
// The CPU port is the master; the video block answers with a one-cycle ack.
interface vdp_cpu_port_if #(
  parameter int ADDR_W = 14
) ();
  logic              vram_req;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              vram_ack;
  logic [7:0]        vram_rdata;

  modport master (
    output vram_req,
    output vram_we,
    output vram_addr,
    output vram_wdata,
    input  vram_ack,
    input  vram_rdata
  );

  modport slave (
    input  vram_req,
    input  vram_we,
    input  vram_addr,
    input  vram_wdata,
    output vram_ack,
    output vram_rdata
  );
endinterface

// File: rtl/vdp_cpu_port.sv
// VDP CPU port: 0x98/0x99 decode, address/register latch, VRAM sequencing,
// read-ahead buffer, frame interrupt flag and status register.
module vdp_cpu_port #(
  parameter int ADDR_W   = 14,
  parameter int NUM_REGS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       io_en,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic       io_port,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       ie,
  input  logic       vblank_pulse,
  input  logic [6:0] spr_status,
  output logic       reg_wr_en,
  output logic [2:0] reg_wr_idx,
  output logic [7:0] reg_wr_data,
  vdp_cpu_port_if.master vram,
  output logic       busy,
  output logic       int_n,
  output logic       err
);

  localparam logic [6:0] NREG = 7'(NUM_REGS);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        latch_q, latch_d;
  logic              flag_q, flag_d;
  logic [7:0]        rbuf_q, rbuf_d;
  logic              f_q, f_d;
  logic              err_q, err_d;
  logic [7:0]        dout_q, dout_d;
  logic              int_n_q, int_n_d;
  logic              rwe_q, rwe_d;
  logic [2:0]        ridx_q, ridx_d;
  logic [7:0]        rdat_q, rdat_d;
  logic              pend_q, pend_d;
  logic              pend_we_q, pend_we_d;
  logic [7:0]        pend_wd_q, pend_wd_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [7:0]        req_wd_q, req_wd_d;
  logic              ovr_q, ovr_d;

  logic wr, rd;
  logic ctrl_wr, data_wr;
  logic ctrl_rd, data_rd;
  logic busy_w;

  always_comb begin
    wr      = io_en & io_wr;
    rd      = io_en & io_rd & ~io_wr;
    ctrl_wr = wr & io_port;
    data_wr = wr & ~io_port;
    ctrl_rd = rd & io_port;
    data_rd = rd & ~io_port;
    busy_w  = (state_q == S_REQ) | pend_q;

    state_d    = state_q;
    addr_d     = addr_q;
    latch_d    = latch_q;
    flag_d     = flag_q;
    rbuf_d     = rbuf_q;
    f_d        = f_q;
    err_d      = err_q;
    dout_d     = dout_q;
    rwe_d      = 1'b0;
    ridx_d     = ridx_q;
    rdat_d     = rdat_q;
    pend_d     = pend_q;
    pend_we_d  = pend_we_q;
    pend_wd_d  = pend_wd_q;
    req_we_d   = req_we_q;
    req_addr_d = req_addr_q;
    req_wd_d   = req_wd_q;
    ovr_d      = ovr_q;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d    = S_REQ;
          req_we_d   = pend_we_q;
          req_addr_d = addr_q;
          req_wd_d   = pend_wd_q;
          pend_d     = 1'b0;
          ovr_d      = 1'b0;
        end
      end
      S_REQ: begin
        if (vram.vram_ack) begin
          state_d = S_IDLE;
          ovr_d   = 1'b0;
          if (!req_we_q) rbuf_d = vram.vram_rdata;
          if (!ovr_q) addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A control-port address load during an op cancels that op's increment.
    if (ctrl_wr) begin
      if (!flag_q) begin
        latch_d = cpu_din;
        flag_d  = 1'b1;
      end else begin
        flag_d = 1'b0;
        if (cpu_din[7]) begin
          if ({1'b0, cpu_din[5:0]} < NREG) begin
            rwe_d  = 1'b1;
            ridx_d = cpu_din[2:0];
            rdat_d = latch_q;
          end
        end else begin
          addr_d = ADDR_W'({cpu_din[5:0], latch_q});
          if (state_d == S_REQ) ovr_d = 1'b1;
          if (!cpu_din[6]) begin
            pend_d    = 1'b1;
            pend_we_d = 1'b0;
          end
        end
      end
    end

    if (data_wr | data_rd) begin
      if (busy_w) begin
        err_d = 1'b1;
      end else begin
        flag_d    = 1'b0;
        pend_d    = 1'b1;
        pend_we_d = data_wr;
        pend_wd_d = cpu_din;
        if (data_wr) rbuf_d = cpu_din;
        else         dout_d = rbuf_q;
      end
    end

    if (ctrl_rd) begin
      dout_d = {f_q, spr_status};
      f_d    = 1'b0;
      flag_d = 1'b0;
    end

    if (vblank_pulse) f_d = 1'b1;
    int_n_d = ~(f_d & ie);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      latch_q    <= '0;
      flag_q     <= 1'b0;
      rbuf_q     <= '0;
      f_q        <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
      int_n_q    <= 1'b1;
      rwe_q      <= 1'b0;
      ridx_q     <= '0;
      rdat_q     <= '0;
      pend_q     <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_wd_q  <= '0;
      req_we_q   <= 1'b0;
      req_addr_q <= '0;
      req_wd_q   <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      latch_q    <= latch_d;
      flag_q     <= flag_d;
      rbuf_q     <= rbuf_d;
      f_q        <= f_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
      int_n_q    <= int_n_d;
      rwe_q      <= rwe_d;
      ridx_q     <= ridx_d;
      rdat_q     <= rdat_d;
      pend_q     <= pend_d;
      pend_we_q  <= pend_we_d;
      pend_wd_q  <= pend_wd_d;
      req_we_q   <= req_we_d;
      req_addr_q <= req_addr_d;
      req_wd_q   <= req_wd_d;
      ovr_q      <= ovr_d;
    end
  end

  assign vram.vram_req   = (state_q == S_REQ);
  assign vram.vram_we    = req_we_q;
  assign vram.vram_addr  = req_addr_q;
  assign vram.vram_wdata = req_wd_q;

  assign cpu_dout    = dout_q;
  assign reg_wr_en   = rwe_q;
  assign reg_wr_idx  = ridx_q;
  assign reg_wr_data = rdat_q;
  assign busy        = busy_w;
  assign int_n       = int_n_q;
  assign err         = err_q;

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
CPU-side port controller for the VDP. It decodes accesses to the data port (0x98) and the control port (0x99) and runs the two-byte address/register latch. It sequences every CPU access to VRAM through a request/acknowledge handshake with the video block and maintains the read-ahead buffer and the auto-incrementing VRAM address. It also owns the frame interrupt flag and the status register.

Parameters:
ADDR_W, 14, VRAM address width (16 KB)
NUM_REGS, 8, number of writable VDP registers; register writes with index >= NUM_REGS are dropped

Ports:
clk  in  1  system clock (cpuClock domain)
reset_n  in  1  asynchronous active-low reset
io_en  in  1  one-cycle strobe: one CPU IO access to a VDP port, already qualified by the CPU clock edge
io_wr  in  1  with io_en: write access
io_rd  in  1  with io_en: read access
io_port  in  1  0 = data port 0x98, 1 = control port 0x99
cpu_din  in  8  CPU write data
cpu_dout  out  8  read data; registered and stable until the next read
ie  in  1  interrupt enable (register 1 bit 5)
vblank_pulse  in  1  one-cycle start-of-vblank pulse
spr_status  in  7  {5S, C, fifth-sprite number[4:0]}
reg_wr_en  out  1  one-cycle register write pulse
reg_wr_idx  out  3  register index
reg_wr_data  out  8  register value
vram_req  out  1  VRAM access request
vram_we  out  1  1 = write, 0 = read; valid while vram_req is high
vram_addr  out  ADDR_W  access address; valid while vram_req is high
vram_wdata  out  8  write data
vram_ack  in  1  one-cycle grant/completion; vram_rdata is valid in the same cycle
vram_rdata  in  8  VRAM read data
busy  out  1  high when a VRAM operation is pending
int_n  out  1  active-low interrupt to the CPU
err  out  1  sticky; set when a data-port access arrives while busy

Behaviour:
- Reset state:
  - addr = 0, latch byte = 0, second-byte flag = 0, read buffer = 0, F = 0, err = 0.
  - cpu_dout = 0, vram_req = 0, reg_wr_en = 0, busy = 0, int_n = 1.
- Control write, flag = 0: store cpu_din in latch byte; set flag = 1.
- Control write, flag = 1: clear flag. The action depends on cpu_din:
  - Bit 7 = 1: pulse reg_wr_en for one cycle the next cycle, with reg_wr_idx = cpu_din[2:0] and reg_wr_data = latch byte. Drop the write if cpu_din[5:0] >= NUM_REGS.
  - Bit 7 = 0: addr <= {cpu_din[5:0], latch byte}.
  - Bit 7 = 0 and bit 6 = 0 (read setup): additionally schedule a prefetch read at the new addr.
- Data write:
  - Clear flag.
  - Schedule a VRAM write of cpu_din at addr.
  - Read buffer <= cpu_din.
- Data read:
  - cpu_dout <= read buffer on the next cycle (latency 1).
  - Clear flag.
  - Schedule a prefetch read at addr.
- Status read (control port read):
  - cpu_dout <= {F, spr_status} on the next cycle.
  - Then clear F and clear flag.
- VRAM FSM: IDLE -> REQ -> IDLE.
  - A scheduled op enters REQ on the next cycle. vram_req, vram_we, vram_addr and vram_wdata are held constant until vram_ack.
  - On vram_ack:
    - Read op: read buffer <= vram_rdata.
    - Any op: addr <= addr + 1, wrapping 2^ADDR_W - 1 -> 0.
    - FSM returns to IDLE in the same cycle, so a new op may start on the following cycle.
  - busy = (state != IDLE) or an op is scheduled.
- Data-port access while busy: the access is ignored; addr, read buffer and flag are unchanged and err is set. The top level holds the CPU in wait on busy, so this case marks a protocol violation. A control-port access while busy is accepted. A control-port addr update takes effect after the pending op's increment is discarded: the new addr wins.
- Interrupt:
  - vblank_pulse sets F.
  - int_n = ~(F & ie), registered.
  - If vblank_pulse and a status read occur in the same cycle: the read returns the old F and F ends set (set wins).
- io_wr and io_rd both high with io_en: treat as a write.
- Reset asserted mid-operation: vram_req drops immediately (asynchronous) and the op is abandoned.

Test Plan:
- Control writes 0x34, then 0x40; data writes 0xAA, 0xBB -> two write requests: (0x0034, 0xAA), then (0x0035, 0xBB), each held until ack; final addr = 0x0036.
- Control writes 0x00, then 0x3F with write-setup bits; data write -> request at 0x3F00. Then control writes 0xFF, 0x7F; data write 0x11 -> request at 0x3FFF; after ack addr = 0x0000.
- Control writes 0x12, then 0x00 (read setup at 0x0012, vram_rdata = 0x5A); then data read -> prefetch at 0x0012. The read returns 0x5A and issues a prefetch at 0x0013.
- Control writes 0xE0, then 0x81 -> single reg_wr_en pulse, idx = 1, data = 0xE0. Control writes 0x01, then 0x8F -> no pulse; flag = 0 afterwards.
- ie = 1, vblank_pulse -> int_n = 0. Status read with spr_status = 0x45 -> cpu_dout = 0xC5, then int_n = 1. Status read coincident with vblank_pulse -> cpu_dout bit 7 = 0 and int_n stays 0.
- Withhold vram_ack for 5 cycles and issue a data write -> err = 1; only the first request appears and busy stays high until ack. Also: a single control byte followed by a status read, then 0x40 0x00 -> the latch restarts and addr = 0x0040.
